// File: rtl/multi_pop_fifo_if.sv
//------------------------------------------------------------------------------
// Module      : multi_pop_fifo_if
// Description : Bundles the push and multi-pop signals of multi_pop_fifo.
//               The slave modport is the FIFO side; the master modport is
//               the side that pushes entries and allocates from the head.
//               Signals:
//                 wr_en, wr_data  - single push port
//                 full            - fill count equals depth
//                 rd_num          - entries to pop this cycle (0..MAX)
//                 rd_grant        - pop of rd_num accepted this cycle
//                 rd_data[i]      - entry at head + i (zero-latency peek)
//                 rd_valid[i]     - slot i holds a live entry
//                 empty, count    - occupancy status
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface multi_pop_fifo_if #(
   parameter int unsigned DATA_WIDTH             = 32,
   parameter int unsigned ADDR_WIDTH             = 4,
   parameter int unsigned MAX_NUM_OF_READS_WIDTH = 1,
   parameter int unsigned MAX_NUM_OF_READS       = 1 << MAX_NUM_OF_READS_WIDTH
) ();

   logic                                         wr_en;
   logic [DATA_WIDTH-1:0]                        wr_data;
   logic                                         full;
   logic [MAX_NUM_OF_READS_WIDTH:0]              rd_num;
   logic                                         rd_grant;
   logic [MAX_NUM_OF_READS-1:0][DATA_WIDTH-1:0]  rd_data;
   logic [MAX_NUM_OF_READS-1:0]                  rd_valid;
   logic                                         empty;
   logic [ADDR_WIDTH:0]                          count;

   modport slave (
      input  wr_en,
      input  wr_data,
      input  rd_num,
      output full,
      output rd_grant,
      output rd_data,
      output rd_valid,
      output empty,
      output count
   );

   modport master (
      output wr_en,
      output wr_data,
      output rd_num,
      input  full,
      input  rd_grant,
      input  rd_data,
      input  rd_valid,
      input  empty,
      input  count
   );

endinterface

`default_nettype wire

// File: rtl/multi_pop_fifo.sv
//------------------------------------------------------------------------------
// Module      : multi_pop_fifo
// Description : Synchronous FIFO with one push port and a head window that
//               exposes and pops up to MAX_NUM_OF_READS entries per cycle.
//               Used as the rename free list: retirement returns tags one at
//               a time, rename peeks and allocates several per cycle.
//               Head reads are combinational peeks; pops commit on the clock
//               edge and are all-or-nothing. Memory can be preloaded with an
//               ascending sequence on reset.
// Ports       : clk   - rising-edge clock
//               reset - asynchronous, active-high; restores preload state
//               bus   - multi_pop_fifo_if.slave (push, pop, status)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module multi_pop_fifo #(
   parameter int unsigned          DATA_WIDTH               = 32,
   parameter int unsigned          ADDR_WIDTH               = 4,
   parameter int unsigned          MAX_NUM_OF_READS_WIDTH   = 1,
   parameter int unsigned          MAX_NUM_OF_READS         = 1 << MAX_NUM_OF_READS_WIDTH,
   parameter bit                   RESET_INITIAL_PUSH_EN    = 1'b1,
   parameter logic [DATA_WIDTH-1:0] RESET_INITIAL_PUSH_START = '0,
   parameter int unsigned          RESET_INITIAL_PUSH_COUNT = 0
) (
   input  wire logic          clk,
   input  wire logic          reset,
   multi_pop_fifo_if.slave    bus
);

   localparam int unsigned c_DEPTH = 1 << ADDR_WIDTH;

   // Preload length, saturated at the depth so an oversized count cannot
   // produce an occupancy the counter cannot represent.
   localparam int unsigned c_PRELOAD =
      !RESET_INITIAL_PUSH_EN               ? 0       :
      (RESET_INITIAL_PUSH_COUNT > c_DEPTH) ? c_DEPTH :
                                             RESET_INITIAL_PUSH_COUNT;

   localparam logic [ADDR_WIDTH:0]   c_FULL       = (ADDR_WIDTH+1)'(c_DEPTH);
   localparam logic [ADDR_WIDTH:0]   c_RST_FILL   = (ADDR_WIDTH+1)'(c_PRELOAD);
   // A full preload leaves the write pointer wrapped back to slot 0.
   localparam logic [ADDR_WIDTH-1:0] c_RST_WR_PTR = ADDR_WIDTH'(c_PRELOAD);

   //---------------------------------------------------------------------------
   // State
   //---------------------------------------------------------------------------
   logic [DATA_WIDTH-1:0]  r_mem [c_DEPTH];
   logic [ADDR_WIDTH-1:0]  r_wr_ptr;
   logic [ADDR_WIDTH-1:0]  r_rd_ptr;
   logic [ADDR_WIDTH:0]    r_fill;

   //---------------------------------------------------------------------------
   // Combinational control
   //---------------------------------------------------------------------------
   logic [MAX_NUM_OF_READS_WIDTH:0]             w_rd_num;
   logic                                        w_wr_acc;
   logic                                        w_rd_grant;
   logic [ADDR_WIDTH:0]                         w_pop_num;
   logic [ADDR_WIDTH:0]                         w_fill_next;
   logic [ADDR_WIDTH-1:0]                       w_rd_ptr_next;
   logic [ADDR_WIDTH-1:0]                       w_wr_ptr_next;
   logic [MAX_NUM_OF_READS-1:0][DATA_WIDTH-1:0] w_rd_data;
   logic [MAX_NUM_OF_READS-1:0]                 w_rd_valid;

   assign w_rd_num = bus.rd_num;

   always_comb begin
      w_wr_acc      = 1'b0;
      w_rd_grant    = 1'b0;
      w_pop_num     = '0;
      w_fill_next   = r_fill;
      w_rd_ptr_next = r_rd_ptr;
      w_wr_ptr_next = r_wr_ptr;

      // A push while full is dropped even if a pop frees space this cycle:
      // the freed slot is only known after the edge.
      w_wr_acc = bus.wr_en && (r_fill != c_FULL);

      // All-or-nothing pop: an out-of-range request or one larger than the
      // current occupancy is refused outright. Entries pushed this cycle are
      // not counted yet, so an empty FIFO never grants.
      w_rd_grant = (w_rd_num != '0)
                && (32'(w_rd_num) <= MAX_NUM_OF_READS)
                && (32'(w_rd_num) <= 32'(r_fill));

      // A granted rd_num never exceeds r_fill (<= depth), so narrowing it to
      // the occupancy width is lossless.
      if (w_rd_grant) begin
         w_pop_num = (ADDR_WIDTH+1)'(w_rd_num);
      end

      w_fill_next   = r_fill + (ADDR_WIDTH+1)'(w_wr_acc) - w_pop_num;
      w_rd_ptr_next = r_rd_ptr + w_pop_num[ADDR_WIDTH-1:0];
      w_wr_ptr_next = r_wr_ptr + ADDR_WIDTH'(w_wr_acc);
   end

   //---------------------------------------------------------------------------
   // Head window: slot i peeks at rd_ptr + i, wrapping modulo depth.
   // Slots beyond the occupancy still show whatever the memory holds.
   //---------------------------------------------------------------------------
   always_comb begin
      w_rd_data  = '0;
      w_rd_valid = '0;
      for (int unsigned i = 0; i < MAX_NUM_OF_READS; i++) begin
         w_rd_data[i]  = r_mem[r_rd_ptr + ADDR_WIDTH'(i)];
         w_rd_valid[i] = (i < 32'(r_fill));
      end
   end

   //---------------------------------------------------------------------------
   // Pointers and occupancy
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= c_RST_WR_PTR;
         r_rd_ptr <= '0;
         r_fill   <= c_RST_FILL;
      end else begin
         r_wr_ptr <= w_wr_ptr_next;
         r_rd_ptr <= w_rd_ptr_next;
         r_fill   <= w_fill_next;
      end
   end

   //---------------------------------------------------------------------------
   // Storage. Reset loads the ascending preload sequence so the free list
   // starts populated without a fill phase; slots past the preload clear.
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned e = 0; e < c_DEPTH; e++) begin
            if (e < c_PRELOAD) begin
               r_mem[e] <= RESET_INITIAL_PUSH_START + DATA_WIDTH'(e);
            end else begin
               r_mem[e] <= '0;
            end
         end
      end else if (w_wr_acc) begin
         r_mem[r_wr_ptr] <= bus.wr_data;
      end
   end

   //---------------------------------------------------------------------------
   // Outputs
   //---------------------------------------------------------------------------
   assign bus.rd_grant = w_rd_grant;
   assign bus.rd_data  = w_rd_data;
   assign bus.rd_valid = w_rd_valid;
   assign bus.full     = (r_fill == c_FULL);
   assign bus.empty    = (r_fill == '0);
   assign bus.count    = r_fill;

endmodule

`default_nettype wire
